// File: rtl/aes_pkg.sv
// Shared AES helpers: skid-buffer state encoding, legal block widths, ShiftRows row offsets
// and the column-major byte index used throughout the datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } skid_state_t;

  localparam int ROWS = 4;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael with 256-bit blocks widens the offsets of the two bottom rows.
  function automatic int row_offset(input int nb, input int r);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic int idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_rows_comb.sv
// Combinational ShiftRows (inv=0) / InvShiftRows (inv=1) for an NB-column state.
// Latency 0; no handshake, pure wiring plus a 2:1 mux per byte.
module shift_rows_comb
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [0:32*NB-1] data,
  input  logic             inv,
  output logic [0:32*NB-1] shifted
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int FWD_SRC = idx(r, (c + row_offset(NB, r)) % NB);
      localparam int INV_SRC = idx(r, (c - row_offset(NB, r) + NB) % NB);
      localparam int DST     = idx(r, c);
      assign shifted[8*DST +: 8] = inv ? data[8*INV_SRC +: 8] : data[8*FWD_SRC +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Registered ShiftRows/InvShiftRows stage, 1-cycle latency, valid/ready with a 2-entry skid buffer
// and registered in_ready. Optional in_bypass port when SHIFT_ROWS_BYPASS_EN is defined.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:32*NB-1] in_data,
  input  logic             in_inv,
`ifdef SHIFT_ROWS_BYPASS_EN
  input  logic             in_bypass,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [0:32*NB-1] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end

  skid_state_t      state;
  logic [0:32*NB-1] skid_data;
  logic [0:32*NB-1] shifted;
  logic [0:32*NB-1] next_word;
  logic             in_fire;
  logic             out_fire;

  shift_rows_comb #(
    .NB(NB)
  ) u_comb (
    .data   (in_data),
    .inv    (in_inv),
    .shifted(shifted)
  );

`ifdef SHIFT_ROWS_BYPASS_EN
  assign next_word = in_bypass ? in_data : shifted;
`else
  assign next_word = shifted;
`endif

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // out_data is the main register itself; skid_data only ever feeds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      skid_data <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_data  <= next_word;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            skid_data <= next_word;
            in_ready  <= 1'b0;
            state     <= ST_FULL;
          end else if (in_fire) begin
            out_data <= next_word;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench for shift_rows_stream at NB=4 and NB=8 against a row-rotation reference model.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [0:127] d4_in_data, d4_out_data;
  logic         d4_in_inv, d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
  logic [0:255] d8_in_data, d8_out_data;
  logic         d8_in_inv, d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
`ifdef SHIFT_ROWS_BYPASS_EN
  logic         d4_in_bypass, d8_in_bypass;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  shift_rows_stream #(.NB(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (d4_in_data),
    .in_inv   (d4_in_inv),
`ifdef SHIFT_ROWS_BYPASS_EN
    .in_bypass(d4_in_bypass),
`endif
    .in_valid (d4_in_valid),
    .in_ready (d4_in_ready),
    .out_data (d4_out_data),
    .out_valid(d4_out_valid),
    .out_ready(d4_out_ready)
  );

  shift_rows_stream #(.NB(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (d8_in_data),
    .in_inv   (d8_in_inv),
`ifdef SHIFT_ROWS_BYPASS_EN
    .in_bypass(d8_in_bypass),
`endif
    .in_valid (d8_in_valid),
    .in_ready (d8_in_ready),
    .out_data (d8_out_data),
    .out_valid(d8_out_valid),
    .out_ready(d8_out_ready)
  );

  // Model state: byte k at m[8k+:8], row k%4, column k/4. Each row is rotated as a list.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input bit inv);
    logic [255:0] o;
    logic [7:0]   row[$];
    int           off;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < nb; c++) row.push_back(d[8*(4*c+r) +: 8]);
      off = (nb == 8 && r >= 2) ? r + 1 : r;
      repeat (off) begin
        if (!inv) row.push_back(row.pop_front());
        else      row.push_front(row.pop_back());
      end
      for (int c = 0; c < nb; c++) o[8*(4*c+r) +: 8] = row[c];
    end
    return o;
  endfunction

  function automatic logic [255:0] from4(input logic [0:127] v);
    logic [255:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = v[8*k +: 8];
    return m;
  endfunction

  function automatic logic [0:127] to4(input logic [255:0] m);
    logic [0:127] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = m[8*k +: 8];
    return v;
  endfunction

  function automatic logic [255:0] from8(input logic [0:255] v);
    logic [255:0] m;
    for (int k = 0; k < 32; k++) m[8*k +: 8] = v[8*k +: 8];
    return m;
  endfunction

  function automatic logic [0:255] to8(input logic [255:0] m);
    logic [0:255] v;
    for (int k = 0; k < 32; k++) v[8*k +: 8] = m[8*k +: 8];
    return v;
  endfunction

  function automatic logic [255:0] counting(input int nbytes);
    logic [255:0] m;
    m = '0;
    for (int k = 0; k < nbytes; k++) m[8*k +: 8] = 8'(k);
    return m;
  endfunction

  function automatic logic [255:0] rand_word(input int nbytes);
    logic [255:0] m;
    m = '0;
    for (int k = 0; k < nbytes; k++) m[8*k +: 8] = 8'($urandom);
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    d4_in_valid = 1'b1; d8_in_valid = 1'b1;
    d4_out_ready = 1'b1; d8_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests += 6;
    if (d4_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid4 got %b want 0", d4_out_valid); end
    if (d4_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready4 got %b want 1", d4_in_ready); end
    if (d4_out_data !== '0) begin n_fail++; $display("FAIL reset_out_data4 got %h want 0", d4_out_data); end
    if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8 got %b want 0", d8_out_valid); end
    if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8 got %b want 1", d8_in_ready); end
    if (d8_out_data !== '0) begin n_fail++; $display("FAIL reset_out_data8 got %h want 0", d8_out_data); end
    d4_in_valid = 1'b0; d8_in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_inverse();
    logic [7:0]   e[16];
    logic [255:0] exp_v;
    e = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
          8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    exp_v = '0;
    for (int k = 0; k < 16; k++) exp_v[8*k +: 8] = e[k];
    d4_in_data = to4(counting(16)); d4_in_inv = 1'b1; d4_in_valid = 1'b1;
    @(negedge clk);
    d4_in_valid = 1'b0;
    n_tests += 2;
    if (d4_out_valid !== 1'b1) begin n_fail++; $display("FAIL inv_latency got out_valid=%b want 1", d4_out_valid); end
    if (from4(d4_out_data) !== exp_v) begin
      n_fail++; $display("FAIL inv_vector got %h want %h", from4(d4_out_data), exp_v[127:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_forward();
    logic [7:0]   e[16];
    logic [255:0] exp_v, fw;
    e = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
          8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    exp_v = '0;
    for (int k = 0; k < 16; k++) exp_v[8*k +: 8] = e[k];
    d4_in_data = to4(counting(16)); d4_in_inv = 1'b0; d4_in_valid = 1'b1;
    @(negedge clk);
    n_tests += 2;
    if (d4_out_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_latency got out_valid=%b want 1", d4_out_valid); end
    if (from4(d4_out_data) !== exp_v) begin
      n_fail++; $display("FAIL fwd_vector got %h want %h", from4(d4_out_data), exp_v[127:0]);
    end
    fw = from4(d4_out_data);
    d4_in_data = to4(fw); d4_in_inv = 1'b1;
    @(negedge clk);
    d4_in_valid = 1'b0;
    n_tests++;
    if (from4(d4_out_data) !== counting(16)) begin
      n_fail++; $display("FAIL fwd_roundtrip got %h want %h", from4(d4_out_data), counting(16));
    end
    @(negedge clk);
  endtask

  task automatic test_nb8();
    logic [255:0] got;
    d8_in_data = to8(counting(32)); d8_in_inv = 1'b0; d8_in_valid = 1'b1;
    @(negedge clk);
    d8_in_valid = 1'b0;
    got = from8(d8_out_data);
    n_tests += 4;
    if (d8_out_valid !== 1'b1) begin n_fail++; $display("FAIL nb8_latency got out_valid=%b want 1", d8_out_valid); end
    if (got[8*3 +: 8] !== 8'h13) begin n_fail++; $display("FAIL nb8_byte3 got %h want 13", got[8*3 +: 8]); end
    if (got[8*2 +: 8] !== 8'h0E) begin n_fail++; $display("FAIL nb8_byte2 got %h want 0e", got[8*2 +: 8]); end
    if (got !== ref_shift(counting(32), 8, 1'b0)) begin
      n_fail++; $display("FAIL nb8_word got %h want %h", got, ref_shift(counting(32), 8, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [255:0] a, b, c;
    bit           ia, ib, ic;
    a = rand_word(16); b = rand_word(16); c = rand_word(16);
    ia = 1'($urandom); ib = 1'($urandom); ic = 1'($urandom);
    d4_out_ready = 1'b0;
    d4_in_data = to4(a); d4_in_inv = ia; d4_in_valid = 1'b1;
    n_tests++;
    if (d4_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_a got %b want 1", d4_in_ready); end
    @(negedge clk);
    n_tests += 3;
    if (d4_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_b got %b want 1", d4_in_ready); end
    if (d4_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_a got %b want 1", d4_out_valid); end
    if (from4(d4_out_data) !== ref_shift(a, 4, ia)) begin n_fail++; $display("FAIL bp_data_a got %h want %h", from4(d4_out_data), ref_shift(a, 4, ia)); end
    d4_in_data = to4(b); d4_in_inv = ib;
    @(negedge clk);
    n_tests += 2;
    if (d4_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got in_ready=%b want 0", d4_in_ready); end
    if (from4(d4_out_data) !== ref_shift(a, 4, ia)) begin n_fail++; $display("FAIL bp_hold1 got %h want %h", from4(d4_out_data), ref_shift(a, 4, ia)); end
    d4_in_data = to4(c); d4_in_inv = ic;
    @(negedge clk);
    n_tests += 3;
    if (d4_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_c got in_ready=%b want 0", d4_in_ready); end
    if (d4_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got %b want 1", d4_out_valid); end
    if (from4(d4_out_data) !== ref_shift(a, 4, ia)) begin n_fail++; $display("FAIL bp_hold2 got %h want %h", from4(d4_out_data), ref_shift(a, 4, ia)); end
    d4_out_ready = 1'b1;
    @(negedge clk);
    n_tests += 3;
    if (d4_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_b got %b want 1", d4_out_valid); end
    if (from4(d4_out_data) !== ref_shift(b, 4, ib)) begin n_fail++; $display("FAIL bp_data_b got %h want %h", from4(d4_out_data), ref_shift(b, 4, ib)); end
    if (d4_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen got in_ready=%b want 1", d4_in_ready); end
    @(negedge clk);
    d4_in_valid = 1'b0;
    n_tests += 2;
    if (d4_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c got %b want 1", d4_out_valid); end
    if (from4(d4_out_data) !== ref_shift(c, 4, ic)) begin n_fail++; $display("FAIL bp_data_c got %h want %h", from4(d4_out_data), ref_shift(c, 4, ic)); end
    @(negedge clk);
    n_tests++;
    if (d4_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got out_valid=%b want 0", d4_out_valid); end
  endtask

  task automatic test_midstream_reset();
    d4_out_ready = 1'b0;
    d4_in_valid = 1'b1; d4_in_inv = 1'b0;
    d4_in_data = to4(rand_word(16));
    @(negedge clk);
    d4_in_data = to4(rand_word(16));
    @(negedge clk);
    n_tests++;
    if (d4_in_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_full got in_ready=%b want 0", d4_in_ready); end
    rst = 1'b1;
    d4_in_data = to4(rand_word(16));
    @(negedge clk);
    n_tests += 3;
    if (d4_out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_out_valid got %b want 0", d4_out_valid); end
    if (d4_in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready got %b want 1", d4_in_ready); end
    if (d4_out_data !== '0) begin n_fail++; $display("FAIL mrst_out_data got %h want 0", d4_out_data); end
    rst = 1'b0;
    d4_in_valid = 1'b0;
    d4_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (d4_out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_stale cycle %0d got out_valid=%b want 0", i, d4_out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] w[16];
    bit           iv[16];
    for (int i = 0; i < 16; i++) begin w[i] = rand_word(16); iv[i] = 1'($urandom); end
    d4_out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        n_tests += 3;
        if (d4_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid word %0d got %b want 1", i - 1, d4_out_valid); end
        if (from4(d4_out_data) !== ref_shift(w[i-1], 4, iv[i-1])) begin
          n_fail++; $display("FAIL b2b_data word %0d got %h want %h", i - 1, from4(d4_out_data), ref_shift(w[i-1], 4, iv[i-1]));
        end
        if (d4_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready word %0d got %b want 1", i - 1, d4_in_ready); end
      end
      if (i < 16) begin
        d4_in_data = to4(w[i]); d4_in_inv = iv[i]; d4_in_valid = 1'b1;
      end else begin
        d4_in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_stream();
    logic [255:0] exp_q[$];
    logic [255:0] cur, last_out, want;
    bit           cur_inv, have, last_stall, done;
    int           sent;
    have = 1'b0; last_stall = 1'b0; done = 1'b0; sent = 0;
    cur = '0; cur_inv = 1'b0; last_out = '0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (last_stall) begin
        n_tests++;
        if (d8_out_valid !== 1'b1 || from8(d8_out_data) !== last_out) begin
          n_fail++; $display("FAIL rnd_stable cycle %0d got v=%b %h want v=1 %h", cyc, d8_out_valid, from8(d8_out_data), last_out);
        end
      end
      if (!have && sent < 200 && $urandom_range(0, 3) != 0) begin
        cur = rand_word(32); cur_inv = 1'($urandom); have = 1'b1;
      end
      d8_in_valid = have; d8_in_data = to8(cur); d8_in_inv = cur_inv;
      d8_out_ready = ($urandom_range(0, 2) != 0);
      if (d8_out_valid && d8_out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra cycle %0d got unexpected word %h want none", cyc, from8(d8_out_data));
        end else begin
          want = exp_q.pop_front();
          if (from8(d8_out_data) !== want) begin
            n_fail++; $display("FAIL rnd_data cycle %0d got %h want %h", cyc, from8(d8_out_data), want);
          end
        end
      end
      if (have && d8_in_ready) begin
        exp_q.push_back(ref_shift(cur, 8, cur_inv));
        have = 1'b0; sent++;
      end
      last_stall = d8_out_valid && !d8_out_ready;
      last_out = from8(d8_out_data);
      done = (sent == 200) && (exp_q.size() == 0);
    end
    @(negedge clk);
    d8_in_valid = 1'b0; d8_out_ready = 1'b1;
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL rnd_timeout sent %0d pending %0d want 200 and 0", sent, exp_q.size()); end
    @(negedge clk);
  endtask

`ifdef SHIFT_ROWS_BYPASS_EN
  task automatic test_bypass();
    d4_out_ready = 1'b1;
    d4_in_bypass = 1'b1; d4_in_inv = 1'($urandom);
    d4_in_data = to4(counting(16)); d4_in_valid = 1'b1;
    @(negedge clk);
    d4_in_valid = 1'b0; d4_in_bypass = 1'b0;
    n_tests += 2;
    if (d4_out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_latency got out_valid=%b want 1", d4_out_valid); end
    if (from4(d4_out_data) !== counting(16)) begin
      n_fail++; $display("FAIL bypass_data got %h want %h", from4(d4_out_data), counting(16));
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d4_in_data = '0; d4_in_inv = 1'b0; d4_in_valid = 1'b0; d4_out_ready = 1'b1;
    d8_in_data = '0; d8_in_inv = 1'b0; d8_in_valid = 1'b0; d8_out_ready = 1'b1;
`ifdef SHIFT_ROWS_BYPASS_EN
    d4_in_bypass = 1'b0; d8_in_bypass = 1'b0;
`endif
    test_reset();
    test_inverse();
    test_forward();
    test_nb8();
    test_backpressure();
    test_midstream_reset();
    test_back_to_back();
    test_random_stream();
`ifdef SHIFT_ROWS_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
